// File: rtl/ll_pkg.sv
// ============================================================================
//  Module      : ll_pkg
//  Description : Shared types and default widths for the line-length feature
//                stage (line_length_window) and its delay buffer. The 1 s
//                window length is shared with the downstream baseline tracker.
//  Contents    : ll_state_e            - EMPTY / FILL / RUN window state
//                LL_DATA_WIDTH         - default raw sample width
//                LL_ADDR_WIDTH         - default circular-buffer index width
//                LL_OUT_WIDTH          - default feature width
//                DIFF_WIDTH            - |x[n]-x[n-1]| width (sample + 1)
//                WIN_LEN_1S            - 1 s window at 250 Hz
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ll_pkg;

   localparam int LL_DATA_WIDTH = 16;
   localparam int LL_ADDR_WIDTH = 8;
   localparam int LL_OUT_WIDTH  = 25;
   localparam int DIFF_WIDTH    = LL_DATA_WIDTH + 1;
   localparam int WIN_LEN_1S    = 250;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      RUN   = 2'd2
   } ll_state_e;

endpackage

`default_nettype wire

// File: rtl/ll_delay_buf.sv
// ============================================================================
//  Module      : ll_delay_buf
//  Description : DEPTH x WIDTH circular buffer holding the most recent
//                absolute differences. One synchronous write port and one
//                asynchronous read port sharing the same address, so the
//                value read in a cycle is the old contents (read-before-write).
//                Maps onto distributed RAM; contents are not reset.
//  Ports       : clk   - clock
//                we    - write enable
//                addr  - shared read/write index
//                wdata - value written at addr on the rising edge
//                rdata - current contents at addr (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ll_delay_buf
   import ll_pkg::*;
#(
   parameter int DEPTH      = WIN_LEN_1S,
   parameter int ADDR_WIDTH = LL_ADDR_WIDTH,
   parameter int WIDTH      = DIFF_WIDTH
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [WIDTH-1:0]      wdata,
   output logic [WIDTH-1:0]      rdata
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   assign rdata = mem_q[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem_q[addr] <= wdata;
      end
   end

endmodule

`default_nettype wire

// File: rtl/line_length_window.sv
// ============================================================================
//  Module      : line_length_window
//  Description : Line-length EEG feature: sliding sum of |x[n]-x[n-1]| over
//                the last WIN_LEN differences. One feature word per accepted
//                sample once the window is full, one cycle after the running
//                sum has been updated.
//  Ports       : clk         - clock, all logic on posedge
//                rst         - synchronous reset, active low
//                en          - active-low enable; high freezes all state
//                din         - raw signed sample
//                din_valid   - strobe qualifying din
//                dout        - feature word (signed, always >= 0), held
//                dout_valid  - one-cycle pulse when dout updates
//                window_full - high once WIN_LEN differences are held
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module line_length_window
   import ll_pkg::*;
#(
   parameter int DATA_WIDTH = LL_DATA_WIDTH,
   parameter int WIN_LEN    = WIN_LEN_1S,
   parameter int ADDR_WIDTH = LL_ADDR_WIDTH,
   parameter int OUT_WIDTH  = LL_OUT_WIDTH
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic signed [DATA_WIDTH-1:0] din,
   input  logic                         din_valid,
   output logic signed [OUT_WIDTH-1:0]  dout,
   output logic                         dout_valid,
   output logic                         window_full
);

   localparam int DIFF_W = DATA_WIDTH + 1;
   localparam int SUM_W  = OUT_WIDTH - 1;
   localparam int CNT_W  = ADDR_WIDTH + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(WIN_LEN - 1);
   localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(WIN_LEN);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   ll_state_e                    state_q, state_d;
   logic signed [DATA_WIDTH-1:0] prev_q, prev_d;
   logic [SUM_W-1:0]             sum_q, sum_d;
   logic [ADDR_WIDTH-1:0]        wptr_q, wptr_d;
   logic [CNT_W-1:0]             count_q, count_d;
   logic                         upd_q, upd_d;
   logic signed [OUT_WIDTH-1:0]  dout_q, dout_d;
   logic                         dout_valid_q, dout_valid_d;
   logic                         window_full_q, window_full_d;

   logic                         din_ge_prev;
   logic [DIFF_W-1:0]            diff;
   logic [DIFF_W-1:0]            buf_rdata;
   logic                         buf_we;
   logic [SUM_W-1:0]             sum_add;
   logic [ADDR_WIDTH-1:0]        wptr_inc;

   // ------------------------------------------------------------------------
   // Absolute difference. Subtracting the smaller from the larger keeps the
   // modular DIFF_W-bit result exact: the magnitude of two full-scale samples
   // is at most 2^DATA_WIDTH-1, even though their signed difference would
   // need one more bit.
   // ------------------------------------------------------------------------
   assign din_ge_prev = (din >= prev_q);

   always_comb begin
      diff = '0;
      if (din_ge_prev) begin
         diff = {din[DATA_WIDTH-1], din} - {prev_q[DATA_WIDTH-1], prev_q};
      end else begin
         diff = {prev_q[DATA_WIDTH-1], prev_q} - {din[DATA_WIDTH-1], din};
      end
   end

   assign sum_add  = sum_q + SUM_W'(diff);
   assign wptr_inc = (wptr_q == LAST_IDX) ? '0 : wptr_q + 1'b1;
   assign buf_we   = rst & ~en & din_valid & (state_q != EMPTY);

   ll_delay_buf #(
      .DEPTH      (WIN_LEN),
      .ADDR_WIDTH (ADDR_WIDTH),
      .WIDTH      (DIFF_W)
   ) u_buf (
      .clk   (clk),
      .we    (buf_we),
      .addr  (wptr_q),
      .wdata (diff),
      .rdata (buf_rdata)
   );

   // ------------------------------------------------------------------------
   // Next-state: window FSM, accumulator and output stage
   // ------------------------------------------------------------------------
   always_comb begin
      state_d       = state_q;
      prev_d        = prev_q;
      sum_d         = sum_q;
      wptr_d        = wptr_q;
      count_d       = count_q;
      upd_d         = upd_q;
      dout_d        = dout_q;
      dout_valid_d  = 1'b0;
      window_full_d = window_full_q;

      if (!en) begin
         // Publish the sum produced by the previous accepted sample. While
         // en is high upd_q is simply held so the word is published on the
         // first enabled edge.
         upd_d = 1'b0;
         if (upd_q) begin
            dout_d        = {1'b0, sum_q};
            dout_valid_d  = 1'b1;
            window_full_d = 1'b1;
         end

         if (din_valid) begin
            prev_d = din;
            unique case (state_q)
               EMPTY: begin
                  state_d = FILL;
               end
               FILL: begin
                  sum_d   = sum_add;
                  wptr_d  = wptr_inc;
                  count_d = count_q + 1'b1;
                  if (count_d == FULL_CNT) begin
                     state_d = RUN;
                     upd_d   = 1'b1;
                  end
               end
               RUN: begin
                  // buf_rdata is the difference leaving the window; it is
                  // always part of sum_q so this never underflows.
                  sum_d  = sum_add - SUM_W'(buf_rdata);
                  wptr_d = wptr_inc;
                  upd_d  = 1'b1;
               end
               default: begin
                  state_d = EMPTY;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= EMPTY;
         prev_q        <= '0;
         sum_q         <= '0;
         wptr_q        <= '0;
         count_q       <= '0;
         upd_q         <= 1'b0;
         dout_q        <= '0;
         dout_valid_q  <= 1'b0;
         window_full_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         prev_q        <= prev_d;
         sum_q         <= sum_d;
         wptr_q        <= wptr_d;
         count_q       <= count_d;
         upd_q         <= upd_d;
         dout_q        <= dout_d;
         dout_valid_q  <= dout_valid_d;
         window_full_q <= window_full_d;
      end
   end

   assign dout        = dout_q;
   assign dout_valid  = dout_valid_q;
   assign window_full = window_full_q;

endmodule

`default_nettype wire
